voice_req_queue: RTL and testbench

VOICE_REQ_QUEUE -- requirements
Module: voice_req_queue

---
 rtl/voice_req_queue.sv | 113 +++++++++++
 tb/tb_voice_req_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_req_queue.sv
// Voice request queue: buffers voice codes in a small FIFO and issues them
// one at a time to the playback stage, spaced by a fixed playback window.
module voice_req_queue #(
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 150_000_000
) (
   input  logic       clk_50M,
   input  logic       s_rst_n,
   input  logic [3:0] req_voice,
   input  logic       req_valid,
   input  logic       flush,
   output logic       req_ready,
   output logic [3:0] select_voice,
   output logic       select_voice_en,
   output logic       busy,
   output logic [4:0] q_count,
   output logic       drop_pulse
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [3:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [27:0]      gap_cnt;
   logic             full;
   logic             req_nonzero;
   logic             do_pop;
   logic             do_write;
   logic             do_drop;
   logic             gap_done;

   // A pop frees a slot on the same edge, so a full FIFO still accepts a write then.
   assign full        = (q_count == 5'(DEPTH));
   assign req_ready   = ~full;
   assign req_nonzero = req_valid && (req_voice != 4'd0);
   assign do_pop      = (state == ISSUE) && !flush;
   assign do_write    = req_nonzero && !flush && (!full || do_pop);
   assign do_drop     = req_nonzero && !flush && full && !do_pop;
   assign busy        = (state != IDLE);
   assign gap_done    = (gap_cnt == 28'(GAP_CYCLES - 1));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (q_count != 5'd0 && !flush) state_next = ISSUE;
         ISSUE:   state_next = flush ? IDLE : WAIT;
         WAIT:    if (gap_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or negedge s_rst_n) begin
      if (!s_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_ff @(posedge clk_50M or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= 5'd0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= 5'd0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({do_write, do_pop})
            2'b10:   q_count <= q_count + 5'd1;
            2'b01:   q_count <= q_count - 5'd1;
            default: q_count <= q_count;
         endcase
      end
   end

   // Storage is left unreset; the pointers alone define what is valid.
   always_ff @(posedge clk_50M) begin
      if (do_write) mem[wr_ptr] <= req_voice;
   end

   always_ff @(posedge clk_50M or negedge s_rst_n) begin
      if (!s_rst_n) begin
         select_voice    <= 4'd0;
         select_voice_en <= 1'b0;
         drop_pulse      <= 1'b0;
      end else begin
         select_voice_en <= do_pop;
         drop_pulse      <= do_drop;
         if (do_pop) select_voice <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk_50M or negedge s_rst_n) begin
      if (!s_rst_n) begin
         gap_cnt <= 28'd0;
      end else if (state == WAIT) begin
         gap_cnt <= gap_done ? 28'd0 : gap_cnt + 28'd1;
      end else begin
         gap_cnt <= 28'd0;
      end
   end

endmodule

// File: tb/tb_voice_req_queue.sv
// Directed bench for voice_req_queue with a short playback window (GAP_CYCLES=20).
module tb_voice_req_queue;

   logic       clk_50M;
   logic       s_rst_n;
   logic [3:0] req_voice;
   logic       req_valid;
   logic       flush;
   logic       req_ready;
   logic [3:0] select_voice;
   logic       select_voice_en;
   logic       busy;
   logic [4:0] q_count;
   logic       drop_pulse;

   int checks   = 0;
   int failures = 0;
   int en_seen;

   voice_req_queue #(.DEPTH(8), .GAP_CYCLES(20)) dut (
      .clk_50M         (clk_50M),
      .s_rst_n         (s_rst_n),
      .req_voice       (req_voice),
      .req_valid       (req_valid),
      .flush           (flush),
      .req_ready       (req_ready),
      .select_voice    (select_voice),
      .select_voice_en (select_voice_en),
      .busy            (busy),
      .q_count         (q_count),
      .drop_pulse      (drop_pulse)
   );

   initial clk_50M = 1'b0;
   always #10 clk_50M = ~clk_50M;

   task automatic tick();
      @(posedge clk_50M);
      #1;
   endtask

   task automatic apply_stimulus(input logic v, input logic [3:0] code, input logic f);
      req_valid = v;
      req_voice = code;
      flush     = f;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      s_rst_n = 1'b0;
      apply_stimulus(1'b0, 4'd0, 1'b0);
      tick();
      tick();
      check_output("rst_q_count", q_count, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_en", select_voice_en, 0);
      check_output("rst_sel", select_voice, 0);
      check_output("rst_ready", req_ready, 1);
      check_output("rst_drop", drop_pulse, 0);

      // Single request on the first edge after release; pulse three cycles later.
      $display("[TB] single request");
      s_rst_n = 1'b1;
      apply_stimulus(1'b1, 4'd5, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      check_output("single_count1", q_count, 1);
      check_output("single_idle", busy, 0);
      tick();
      check_output("single_issue_busy", busy, 1);
      check_output("single_issue_en", select_voice_en, 0);
      tick();
      check_output("single_en", select_voice_en, 1);
      check_output("single_sel", select_voice, 5);
      check_output("single_count0", q_count, 0);
      tick();
      check_output("single_en_off", select_voice_en, 0);
      repeat (18) tick();
      check_output("single_wait_end_busy", busy, 1);
      check_output("single_sel_hold", select_voice, 5);
      tick();
      check_output("single_idle_again", busy, 0);

      // Burst of three codes: pulses 22 cycles apart, in order.
      $display("[TB] burst 1,2,3");
      apply_stimulus(1'b1, 4'd1, 1'b0);
      tick();
      apply_stimulus(1'b1, 4'd2, 1'b0);
      tick();
      apply_stimulus(1'b1, 4'd3, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      check_output("burst_en1", select_voice_en, 1);
      check_output("burst_sel1", select_voice, 1);
      check_output("burst_count1", q_count, 2);
      for (int k = 2; k <= 3; k++) begin
         repeat (21) tick();
         check_output("burst_gap_no_en", select_voice_en, 0);
         tick();
         check_output("burst_en", select_voice_en, 1);
         check_output("burst_sel", select_voice, 32'(k));
         check_output("burst_count", q_count, 32'(3 - k));
      end
      repeat (20) tick();
      check_output("burst_done_busy", busy, 0);

      // Zero code is ignored entirely.
      $display("[TB] zero code");
      apply_stimulus(1'b1, 4'd0, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      check_output("zero_count", q_count, 0);
      check_output("zero_drop", drop_pulse, 0);
      tick();
      check_output("zero_no_issue", busy, 0);

      // Flush landing on the ISSUE cycle suppresses the pop and the pulse.
      $display("[TB] flush during issue");
      apply_stimulus(1'b1, 4'd2, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      tick();
      check_output("fissue_busy", busy, 1);
      apply_stimulus(1'b0, 4'd0, 1'b1);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      check_output("fissue_en", select_voice_en, 0);
      check_output("fissue_idle", busy, 0);
      check_output("fissue_count", q_count, 0);
      tick();
      check_output("fissue_en2", select_voice_en, 0);
      check_output("fissue_sel_hold", select_voice, 3);

      // Fill the FIFO during WAIT, overflow once, then write on the pop cycle.
      $display("[TB] fill and overflow");
      apply_stimulus(1'b1, 4'd7, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      tick();
      tick();
      check_output("fill_start_en", select_voice_en, 1);
      check_output("fill_start_sel", select_voice, 7);
      for (int i = 1; i <= 8; i++) begin
         apply_stimulus(1'b1, 4'(i), 1'b0);
         tick();
      end
      check_output("fill_count8", q_count, 8);
      check_output("fill_ready_low", req_ready, 0);
      apply_stimulus(1'b1, 4'd9, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      check_output("fill_drop", drop_pulse, 1);
      check_output("fill_count_kept", q_count, 8);
      tick();
      check_output("fill_drop_off", drop_pulse, 0);
      repeat (11) tick();
      check_output("fill_issue_busy", busy, 1);
      check_output("fill_issue_en", select_voice_en, 0);
      apply_stimulus(1'b1, 4'd10, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      check_output("fill_pop_en", select_voice_en, 1);
      check_output("fill_pop_sel", select_voice, 1);
      check_output("fill_pop_count", q_count, 8);
      check_output("fill_pop_drop", drop_pulse, 0);

      // Flush while WAIT runs: FIFO empties, WAIT completes, nothing more issues.
      $display("[TB] flush during wait");
      tick();
      apply_stimulus(1'b1, 4'd4, 1'b1);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      check_output("fwait_count", q_count, 0);
      check_output("fwait_ready", req_ready, 1);
      check_output("fwait_busy", busy, 1);
      check_output("fwait_drop", drop_pulse, 0);
      repeat (17) tick();
      check_output("fwait_end_busy", busy, 1);
      tick();
      check_output("fwait_idle", busy, 0);
      en_seen = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (select_voice_en) en_seen++;
      end
      check_output("fwait_no_pulse", en_seen, 0);

      // Reset in the middle of WAIT with entries queued.
      $display("[TB] reset during wait");
      apply_stimulus(1'b1, 4'd3, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      tick();
      tick();
      check_output("rwait_en", select_voice_en, 1);
      for (int i = 4; i <= 6; i++) begin
         apply_stimulus(1'b1, 4'(i), 1'b0);
         tick();
      end
      apply_stimulus(1'b0, 4'd0, 1'b0);
      check_output("rwait_count3", q_count, 3);
      check_output("rwait_busy", busy, 1);
      s_rst_n = 1'b0;
      #2;
      check_output("rwait_rst_count", q_count, 0);
      check_output("rwait_rst_busy", busy, 0);
      check_output("rwait_rst_sel", select_voice, 0);
      check_output("rwait_rst_en", select_voice_en, 0);
      check_output("rwait_rst_ready", req_ready, 1);
      check_output("rwait_rst_drop", drop_pulse, 0);
      tick();
      s_rst_n = 1'b1;
      en_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (select_voice_en) en_seen++;
      end
      check_output("rwait_no_pulse", en_seen, 0);
      check_output("rwait_idle", busy, 0);
      apply_stimulus(1'b1, 4'd9, 1'b0);
      tick();
      apply_stimulus(1'b0, 4'd0, 1'b0);
      tick();
      tick();
      check_output("rwait_new_en", select_voice_en, 1);
      check_output("rwait_new_sel", select_voice, 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
